// File: rtl/pixel_cfg_pkg.sv
// rtl/pixel_cfg_pkg.sv - shared constants and state encoding for the pixel configuration path
package pixel_cfg_pkg;

  localparam int DEF_FIFO_WIDTH = 36;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int LAST_BIT       = DEF_FIFO_WIDTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT_Q = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_LOAD   = 3'd4,
    ST_DONE   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/serial_config_tx_sclk_phase_gen.sv
// rtl/serial_config_tx_sclk_phase_gen.sv - sclk half-period divider, low phase first after clear
module sclk_phase_gen #(
  parameter int DIV_HALF = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic phase_tick_o,
  output logic sclk_hi_o
);

  localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hi_q, hi_d;

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    if (clr_i) begin
      cnt_d = '0;
      hi_d  = 1'b0;
    end else if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        hi_d  = ~hi_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  assign phase_tick_o = en_i && (cnt_q == CNT_LAST);
  assign sclk_hi_o    = hi_q;

endmodule

// File: rtl/serial_config_tx.sv
// rtl/serial_config_tx.sv - pops config words from a FIFO and shifts them MSB-first on sclk/sdin,
// then pulses sload to latch the frame into the chip.
module serial_config_tx
  import pixel_cfg_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIV_HALF   = 5,
  parameter int LOAD_LEN   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  fifo_empty_i,
  input  logic [FIFO_WIDTH-1:0] fifo_q_i,
  output logic                  fifo_rd_en_o,
  output logic                  sclk_o,
  output logic                  sdin_o,
  output logic                  sload_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  underrun_o
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int LW = $clog2(LOAD_LEN + 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  last_q, last_d;
  logic                  sdin_q, sdin_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]         load_cnt_q, load_cnt_d;
  logic                  underrun_q, underrun_d;
  logic                  first_q, first_d;
  logic                  phase_tick, sclk_hi, bit_end;
  logic                  unused_reserved;

  assign unused_reserved = ^fifo_q_i[FIFO_WIDTH-2:DATA_WIDTH];

  sclk_phase_gen #(.DIV_HALF(DIV_HALF)) u_phase (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (state_q == ST_SHIFT),
    .clr_i        (state_q == ST_WAIT_Q),
    .phase_tick_o (phase_tick),
    .sclk_hi_o    (sclk_hi)
  );

  // A bit is complete at the last cycle of its high phase.
  assign bit_end = phase_tick && sclk_hi;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    last_d       = last_q;
    sdin_d       = sdin_q;
    bit_cnt_d    = bit_cnt_q;
    load_cnt_d   = load_cnt_q;
    underrun_d   = underrun_q;
    first_d      = first_q;
    fifo_rd_en_o = 1'b0;
    sload_o      = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_FETCH;
          underrun_d = 1'b0;
          first_d    = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!fifo_empty_i) begin
          fifo_rd_en_o = 1'b1;
          first_d      = 1'b0;
          state_d      = ST_WAIT_Q;
        end else if (!first_q) begin
          underrun_d = 1'b1;
        end
      end
      ST_WAIT_Q: begin
        shreg_d   = fifo_q_i[DATA_WIDTH-1:0];
        last_d    = fifo_q_i[FIFO_WIDTH-1];
        sdin_d    = fifo_q_i[DATA_WIDTH-1];
        bit_cnt_d = BW'(DATA_WIDTH - 1);
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_end) begin
          shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_cnt_q == '0) begin
            load_cnt_d = '0;
            if (last_q) begin
              state_d = ST_LOAD;
              sdin_d  = 1'b0;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            sdin_d    = shreg_q[DATA_WIDTH-2];
          end
        end
      end
      ST_LOAD: begin
        sload_o = 1'b1;
        if (load_cnt_q == LW'(LOAD_LEN - 1)) begin
          state_d = ST_DONE;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      sdin_q     <= 1'b0;
      bit_cnt_q  <= '0;
      load_cnt_q <= '0;
      underrun_q <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      sdin_q     <= sdin_d;
      bit_cnt_q  <= bit_cnt_d;
      load_cnt_q <= load_cnt_d;
      underrun_q <= underrun_d;
      first_q    <= first_d;
    end
  end

  assign sclk_o     = (state_q == ST_SHIFT) && sclk_hi;
  assign sdin_o     = sdin_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_serial_config_tx.sv
// tb/tb_serial_config_tx.sv - directed self-checking bench for serial_config_tx
module tb_serial_config_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        fifo_empty;
  logic [35:0] fifo_q;
  logic        fifo_rd_en, sclk, sdin, sload, busy, done, underrun;

  int checks = 0;
  int fails = 0;

  serial_config_tx dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .fifo_empty_i (fifo_empty),
    .fifo_q_i     (fifo_q),
    .fifo_rd_en_o (fifo_rd_en),
    .sclk_o       (sclk),
    .sdin_o       (sdin),
    .sload_o      (sload),
    .busy_o       (busy),
    .done_o       (done),
    .underrun_o   (underrun)
  );

  always #5 clk = ~clk;

  // Standard (non-FWFT) FIFO model
  logic [35:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Line monitor, sampled on the falling clk edge
  logic mon_clr = 1'b0;
  logic sclk_prev = 1'b0;
  logic bits [$];
  int   rise_cyc [$];
  int   cyc, rd_cnt, sload_cnt, sload_first, done_cnt, sclk_bad;
  int   rd_bad = 0;
  always @(negedge clk) begin
    if (fifo_rd_en === 1'b1 && fifo_empty) rd_bad++;
    if (mon_clr) begin
      bits.delete();
      rise_cyc.delete();
      cyc = 0; rd_cnt = 0; sload_cnt = 0; sload_first = 0; done_cnt = 0; sclk_bad = 0;
    end else begin
      cyc++;
      if (sclk === 1'b1 && sclk_prev === 1'b0) begin
        bits.push_back(sdin);
        rise_cyc.push_back(cyc);
      end
      if (fifo_rd_en === 1'b1) rd_cnt++;
      if (sload === 1'b1) begin
        if (sload_cnt == 0) sload_first = cyc;
        sload_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      if (sclk === 1'b1 && (fifo_rd_en === 1'b1 || sload === 1'b1)) sclk_bad++;
    end
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [35:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic begin_frame();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      step();
      n++;
    end
    check(tag, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic wait_bits(input string tag, input int nb);
    int n = 0;
    while (bits.size() < nb && n < 3000) begin
      step();
      n++;
    end
    check(tag, 64'(bits.size() >= nb), 64'd1);
  endtask

  function automatic logic [31:0] word_at(input int idx);
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], bits[idx*32 + i]};
    return w;
  endfunction

  initial begin
    repeat (3) step();
    check("reset_outputs", {57'd0, sclk, sdin, sload, busy, done, underrun, fifo_rd_en}, 64'd0);
    rst = 1'b0;
    step();

    // Single-word frame
    push(36'h8_A5A5_F00F);
    begin_frame();
    check("t1_busy", 64'(busy), 64'd1);
    step();
    step();
    check("t1_first_bit", {62'd0, sclk, sdin}, 64'b01);
    wait_done("t1_done_timeout");
    check("t1_nbits", 64'(bits.size()), 64'd32);
    check("t1_word", 64'(word_at(0)), 64'hA5A5_F00F);
    check("t1_sclk_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'd10);
    check("t1_sclk_span", 64'(rise_cyc[31] - rise_cyc[0]), 64'd310);
    check("t1_sload_len", 64'(sload_cnt), 64'd4);
    check("t1_sload_pos", 64'(sload_first - rise_cyc[31]), 64'd5);
    check("t1_rd_cnt", 64'(rd_cnt), 64'd1);
    step();
    step();
    check("t1_idle", {62'd0, busy, done}, 64'd0);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);

    // Three-word frame
    push(36'h0_0000_0001);
    push(36'h0_8000_0000);
    push(36'h8_FFFF_FFFF);
    begin_frame();
    wait_done("t2_done_timeout");
    check("t2_nbits", 64'(bits.size()), 64'd96);
    check("t2_word0", 64'(word_at(0)), 64'h0000_0001);
    check("t2_word1", 64'(word_at(1)), 64'h8000_0000);
    check("t2_word2", 64'(word_at(2)), 64'hFFFF_FFFF);
    check("t2_gap", 64'(rise_cyc[32] - rise_cyc[31]), 64'd12);
    check("t2_sload_len", 64'(sload_cnt), 64'd4);
    check("t2_sload_pos", 64'(sload_first - rise_cyc[95]), 64'd5);
    check("t2_rd_cnt", 64'(rd_cnt), 64'd3);
    check("t2_sclk_low_gaps", 64'(sclk_bad), 64'd0);

    // Underrun mid-frame
    push(36'h0_1234_5678);
    begin_frame();
    wait_bits("t3_word1_timeout", 32);
    repeat (200) step();
    check("t3_underrun_set", 64'(underrun), 64'd1);
    check("t3_hold", {61'd0, sclk, busy, sload}, 64'b010);
    check("t3_no_bits", 64'(bits.size()), 64'd32);
    push(36'h8_CAFE_BABE);
    wait_done("t3_done_timeout");
    check("t3_word1", 64'(word_at(0)), 64'h1234_5678);
    check("t3_word2", 64'(word_at(1)), 64'hCAFE_BABE);
    check("t3_sload_len", 64'(sload_cnt), 64'd4);
    check("t3_sticky", 64'(underrun), 64'd1);
    step();
    push(36'h8_0000_0003);
    begin_frame();
    check("t3_cleared", 64'(underrun), 64'd0);
    wait_done("t3b_done_timeout");
    check("t3b_word", 64'(word_at(0)), 64'h0000_0003);

    // Start ignored while busy
    push(36'h8_0F0F_3C3C);
    begin_frame();
    wait_bits("t4_bits_timeout", 10);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t4_done_timeout");
    repeat (20) step();
    check("t4_word", 64'(word_at(0)), 64'h0F0F_3C3C);
    check("t4_nbits", 64'(bits.size()), 64'd32);
    check("t4_rd_cnt", 64'(rd_cnt), 64'd1);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);
    check("t4_idle", 64'(busy), 64'd0);

    // Reset mid-frame
    push(36'h8_DEAD_BEEF);
    begin_frame();
    wait_bits("t5_bits_timeout", 10);
    rst = 1'b1;
    step();
    check("t5_reset_outputs", {58'd0, sclk, sdin, sload, busy, done, fifo_rd_en}, 64'd0);
    rst = 1'b0;
    repeat (400) step();
    check("t5_no_sload", 64'(sload_cnt), 64'd0);
    check("t5_no_done", 64'(done_cnt), 64'd0);
    push(36'h8_1357_9BDF);
    begin_frame();
    wait_done("t5b_done_timeout");
    check("t5b_word", 64'(word_at(0)), 64'h1357_9BDF);
    check("t5b_sload_len", 64'(sload_cnt), 64'd4);

    // Start with FIFO empty
    step();
    begin_frame();
    check("t6_busy", {62'd0, busy, fifo_rd_en}, 64'b10);
    repeat (50) step();
    check("t6_no_underrun", 64'(underrun), 64'd0);
    check("t6_waiting", {61'd0, sclk, busy, 1'b0} | 64'(rd_cnt), 64'b010);
    push(36'h8_DA5A_0001);
    #1;
    check("t6_rd_en", 64'(fifo_rd_en), 64'd1);
    step();
    step();
    check("t6_first_bit", {62'd0, sclk, sdin}, 64'b01);
    wait_done("t6_done_timeout");
    check("t6_word", 64'(word_at(0)), 64'hDA5A_0001);
    check("t6_underrun_end", 64'(underrun), 64'd0);
    check("rd_en_while_empty", 64'(rd_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_config_tx.md
Name: serial_config_tx

Overview:
- Transmit side of the pixel configuration path.
- Software loads config words into a 36-bit FIFO through the control interface. On a start pulse, this block pops the words and shifts the data bits out MSB-first on a slow serial clock (sclk/sdin).
- After the last bit of a frame it issues a load strobe (sload) to latch the config into the chip.
- It is the outbound counterpart of the capture path, which deserializes chip data into a FIFO.

Parameters:
- FIFO_WIDTH, 36, width of fifo_q. Bit FIFO_WIDTH-1 is the LAST flag; bits [FIFO_WIDTH-2:DATA_WIDTH] are reserved and ignored.
- DATA_WIDTH, 32, payload bits per word shifted out.
- DIV_HALF, 5, clk cycles per sclk half-period (must be ≥1).
- LOAD_LEN, 4, clk cycles sload is held high.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse (already in clk domain); begins a frame.
- fifo_empty  input  1  FIFO empty flag.
- fifo_q  input  FIFO_WIDTH  FIFO read data; valid the cycle after fifo_rd_en (standard, non-FWFT FIFO).
- fifo_rd_en  output  1  FIFO pop, one cycle per word.
- sclk  output  1  serial clock to chip; idle low.
- sdin  output  1  serial data; changes on sclk falling phase, chip samples on rising edge.
- sload  output  1  config latch strobe.
- busy  output  1  high from accepted start until DONE exit.
- done  output  1  one-cycle pulse at frame completion.
- underrun  output  1  sticky error: FIFO empty mid-frame; cleared by next accepted start or by rst.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset mid-frame aborts immediately; no sload is issued.
- States: IDLE, FETCH, WAIT_Q, SHIFT, LOAD, DONE.
- IDLE:
  - start=1 → FETCH, busy=1, underrun cleared.
  - start while busy is ignored.
- FETCH:
  - If !fifo_empty: fifo_rd_en=1 for exactly one cycle → WAIT_Q.
  - If empty: stay, holding sclk=0 and sdin unchanged.
  - If empty and this is not the first word of the frame: set underrun and keep waiting. The frame resumes when data arrives.
- WAIT_Q:
  - Register fifo_q[DATA_WIDTH-1:0] into the shift register and fifo_q[FIFO_WIDTH-1] into last_r.
  - Bit counter = DATA_WIDTH-1 → SHIFT.
- SHIFT, per bit (2*DIV_HALF clk cycles):
  - Low phase, DIV_HALF cycles: sclk=0, sdin = shreg[MSB] from the phase's first cycle.
  - High phase, DIV_HALF cycles: sclk=1.
  - At the end of the high phase: shift left by 1 and decrement the counter.
  - After bit 0: → LOAD if last_r, else → FETCH.
  - The bit stream has no gaps between words other than the FETCH/WAIT_Q cycles; sclk stays low during those.
- LOAD: sclk=0, sdin=0, sload=1 for LOAD_LEN cycles → DONE.
- DONE: done=1 for one cycle, busy=0 next cycle → IDLE.
- Latency:
  - start to first sdin valid is 3 cycles if the FIFO is non-empty (start→FETCH→WAIT_Q→SHIFT).
  - One word takes 2 + DATA_WIDTH*2*DIV_HALF cycles.
- Counters:
  - Phase counter: clog2(DIV_HALF) bits.
  - Bit counter: clog2(DATA_WIDTH) bits.
  - Load counter: clog2(LOAD_LEN+1) bits.
- A FIFO empty condition never causes fifo_rd_en to assert.
- fifo_rd_en is never asserted outside FETCH.

Decomposition:
- Shared package pixel_cfg_pkg holds:
  - the state encoding;
  - LAST_BIT = FIFO_WIDTH-1;
  - default DATA_WIDTH/FIFO_WIDTH constants, shared with the capture path.
- One natural sub-module: sclk_phase_gen. It produces phase_tick and sclk_hi from DIV_HALF, is enabled only in SHIFT, and clears on entry to SHIFT.
- The FSM and shift register stay in the top module.

Test Plan:
- Single-word frame:
  - Stimulus: FIFO holds 0x8_A5A5_F00F (LAST=1), DIV_HALF=5, pulse start.
  - Response: sdin sampled on 32 sclk rising edges = 0xA5A5F00F MSB-first; each sclk period 10 clk; sload high 4 cycles after last bit; done pulse; busy low; fifo_rd_en asserted exactly once.
- Three-word frame:
  - Stimulus: words 0x0_00000001, 0x0_80000000, 0x8_FFFFFFFF.
  - Response: 96 bits in order; sclk low during the 2-cycle refill gaps; a single sload, only after word 3.
- Underrun:
  - Stimulus: write word 1 (LAST=0); start; write word 2 (LAST=1) 200 cycles after word 1 finishes.
  - Response: underrun=1 and sclk held low during the wait; transfer resumes and completes with sload and done. Next start clears underrun.
- Start ignored while busy:
  - Stimulus: second start pulse mid-SHIFT.
  - Response: no change in bit stream or rd_en count; exactly one done.
- Reset mid-frame:
  - Stimulus: rst asserted for 1 cycle at bit 10 of word 1.
  - Response: next cycle sclk=sdin=sload=busy=done=0, state IDLE, no sload ever issued for that frame. A new start with a fresh FIFO transmits correctly.
- Start with FIFO empty:
  - Stimulus: start, FIFO empty 50 cycles, then one LAST word.
  - Response: underrun stays 0 (first word); transmission begins 3 cycles after fifo_empty deasserts.
